// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states
// and the step-counter width helper.
package mips_muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mips_negate.sv
// Combinational two's-complement negate, applied only when en is high.
module mips_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         en,
    output logic [W-1:0] result
);

    assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Operates on magnitudes; signs are reapplied in a single FIX cycle.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               neg_res_q, neg_rem_q, div_zero_q;
    logic [WIDTH-1:0]   divr_q, acc_hi, acc_lo;

    logic               op_signed, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;

    always_comb begin
        op_signed = 1'b0;
        case (op)
            OP_MULT:  op_signed = 1'b1;
            OP_MULTU: op_signed = 1'b0;
            OP_DIV:   op_signed = 1'b1;
            OP_DIVU:  op_signed = 1'b0;
            default:  op_signed = 1'b0;
        endcase
    end

    assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mips_negate #(.W(WIDTH)) u_neg_a (
        .value (a),
        .en    (op_signed & a[WIDTH-1]),
        .result(a_mag)
    );

    mips_negate #(.W(WIDTH)) u_neg_b (
        .value (b),
        .en    (op_signed & b[WIDTH-1]),
        .result(b_mag)
    );

    mips_negate #(.W(2*WIDTH)) u_neg_prod (
        .value ({acc_hi, acc_lo}),
        .en    (neg_res_q),
        .result(prod_fix)
    );

    mips_negate #(.W(WIDTH)) u_neg_quo (
        .value (acc_lo),
        .en    (neg_res_q),
        .result(quo_fix)
    );

    mips_negate #(.W(WIDTH)) u_neg_rem (
        .value (acc_hi),
        .en    (neg_rem_q),
        .result(rem_fix)
    );

    // acc_hi holds the partial product / partial remainder; acc_lo holds the
    // multiplier being shifted out / the dividend shifting into the quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? divr_q : '0)};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, divr_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            divr_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        op_q       <= op;
                        neg_res_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q  <= op_signed & a[WIDTH-1];
                        div_zero_q <= (b == '0);
                        divr_q     <= b_mag;
                        acc_hi     <= '0;
                        acc_lo     <= a_mag;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // Divide-by-zero remainder already equals a after sign fix.
                    if (is_div) begin
                        lo <= div_zero_q ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: arithmetic reference model plus directed
// and randomized operations.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            OP_MULT:  p = sx * sy;
            OP_MULTU: p = {32'b0, x} * {32'b0, y};
            default: begin
                if (y == '0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == OP_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {x % y, x / y};
                end
            end
        endcase
        return p;
    endfunction

    int           m_cnt = 0;
    logic [W-1:0] m_hi, m_lo;
    logic         m_done;
    logic [63:0]  m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_pend <= ref_result(op, a, b);
                    m_cnt  <= LAT;
                end else begin
                    if (hi_we) m_hi <= wdata;
                    if (lo_we) m_lo <= wdata;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("done", 32'(done), 32'(m_done));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = -1;
        nb  = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k - 1;
                break;
            end
            if (busy) nb++;
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] x, y, eh, el;
    } vec_t;

    vec_t vecs[9] = '{
        '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
        '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
        '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
        '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14},
        '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
        '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
        '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
        '{OP_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF}
    };

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat, nb;
        logic [63:0] r;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            r = ref_result(vecs[i].o, vecs[i].x, vecs[i].y);
            check($sformatf("model_hi%0d", i), r[63:32], vecs[i].eh);
            check($sformatf("model_lo%0d", i), r[31:0], vecs[i].el);
            @(negedge clk);
            issue(vecs[i].o, vecs[i].x, vecs[i].y);
            wait_done(lat, nb);
            check($sformatf("latency%0d", i), 32'(lat), 32'(LAT));
            check($sformatf("busy_cycles%0d", i), 32'(nb), 32'(LAT));
            check($sformatf("hi%0d", i), hi, vecs[i].eh);
            check($sformatf("lo%0d", i), lo, vecs[i].el);
        end

        // back-to-back start in the done cycle
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, nb);
        check("b2b_latency", 32'(lat), 32'(LAT));
        check("b2b_lo", lo, 32'd42);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // start and hi_we while busy are ignored
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        wait_done(lat, nb);
        check("busy_start_hi", hi, 32'd2);
        check("busy_start_lo", lo, 32'd14);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi", hi, 32'hA5A5_A5A5);
        check("mthi_lo_kept", lo, 32'd14);

        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1 start = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_with_start", lo, 32'd14);
        wait_done(lat, nb);
        check("mtlo_start_lo", lo, 32'd42);
        check("mtlo_start_hi", hi, 32'd0);

        // asynchronous reset mid-calculation
        @(negedge clk);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, nb);
        check("post_rst_latency", 32'(lat), 32'(LAT));
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                wdata = W'($urandom);
                @(posedge clk);
                #1 hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
            lo_we = 1'($urandom_range(0, 1));
            wdata = W'($urandom);
            issue(2'($urandom_range(0, 3)), pick(), pick());
            lo_we = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                op = 2'($urandom_range(0, 3)); a = W'($urandom); b = W'($urandom);
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = W'($urandom);
                @(posedge clk);
                #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            wait_done(lat, nb);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
